// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store unit between execute and a byte-lane
// data memory. It decodes funct3 into byte enables, lane-shifts store data,
// and aligns plus sign/zero-extends load data. One response per request.
//
// Optional feature macro: LSU_SPLIT_CROSSING_EN
//   defined   : word-crossing accesses are split over two memory cycles.
//   undefined : every word-crossing access returns an error response.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_RESP,
    S_ERR_RESP
  } state_t;

  state_t r_state, w_state_nxt;

  // Registered outputs and their next values.
  logic              r_req_ready,  w_req_ready_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
  logic              r_resp_err,   w_resp_err_nxt;
  logic              r_mem_en,     w_mem_en_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [3:0]        r_mem_be,     w_mem_be_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata,  w_mem_wdata_nxt;

  // Request context captured at accept.
  logic              r_we;
  logic [1:0]        r_off;
  logic [1:0]        r_size_code;
  logic              r_unsigned;
  logic              r_cross;
  logic [ADDR_W-1:0] r_word1;
  logic [31:0]       r_wdata_hi;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_rdata0;

  // Request decode, evaluated on the incoming request.
  logic              w_accept;
  logic              w_size_ok;
  logic [3:0]        w_mask;
  logic [2:0]        w_size;
  logic [1:0]        w_off;
  logic [2:0]        w_end;
  logic              w_cross;
  logic [ADDR_W-1:0] w_word0;
  logic              w_f3_err;
  logic              w_range_err;
  logic              w_cross_err;
  logic              w_err;
  logic [63:0]       w_st_wide;
  logic [7:0]        w_st_be;

  // Load alignment path.
  logic [31:0]       w_ld_lo;
  logic [31:0]       w_ld_hi;
  logic [31:0]       w_ld_sh;
  logic [31:0]       w_ld_data;

  assign w_accept = r_req_ready & i_req_valid;

  // Map funct3 width code to byte mask and access size.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_size_ok = 1'b1;
    w_mask    = 4'b0001;
    w_size    = 3'd1;
    case (i_req_funct3[1:0])
      2'b00:   begin w_mask = 4'b0001; w_size = 3'd1; end
      2'b01:   begin w_mask = 4'b0011; w_size = 3'd2; end
      2'b10:   begin w_mask = 4'b1111; w_size = 3'd4; end
      default: w_size_ok = 1'b0;
    endcase
  end

  // Bit 2 (unsigned) is only legal for LBU/LHU; stores never take it.
  assign w_f3_err    = ~w_size_ok | (i_req_funct3[2] & (i_req_we | i_req_funct3[1]));
  assign w_off       = i_req_addr[1:0];
  assign w_end       = {1'b0, w_off} + w_size;
  assign w_cross     = (w_end > 3'd4);
  assign w_word0     = i_req_addr[ADDR_W+1:2];
  assign w_range_err = |i_req_addr[31:ADDR_W+2];

`ifdef LSU_SPLIT_CROSSING_EN
  // The second word of a split would wrap past the top of memory.
  assign w_cross_err = w_cross & (&w_word0);
`else
  assign w_cross_err = w_cross;
`endif

  assign w_err     = w_f3_err | w_range_err | w_cross_err;
  assign w_st_wide = {32'd0, i_req_wdata} << {w_off, 3'b000};
  assign w_st_be   = {4'd0, w_mask} << w_off;

  // For a split load the first word was parked in r_rdata0 during ACC1 and the
  // second word is on the bus in CAP; otherwise the single word is on the bus.
  assign w_ld_lo = r_cross ? r_rdata0 : i_mem_rdata;
  assign w_ld_hi = r_cross ? i_mem_rdata : 32'd0;
  assign w_ld_sh = (w_ld_lo >> {r_off, 3'b000}) |
                   (w_ld_hi << (6'd32 - {1'b0, r_off, 3'b000}));

  // Keep the low 1/2/4 bytes and extend according to the unsigned bit.
  always_comb begin
    w_ld_data = w_ld_sh;
    case (r_size_code)
      2'b00:   w_ld_data = {{24{~r_unsigned & w_ld_sh[7]}},  w_ld_sh[7:0]};
      2'b01:   w_ld_data = {{16{~r_unsigned & w_ld_sh[15]}}, w_ld_sh[15:0]};
      default: w_ld_data = w_ld_sh;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = 32'd0;
    w_resp_err_nxt   = 1'b0;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_be_nxt     = 4'd0;
    w_mem_addr_nxt   = '0;
    w_mem_wdata_nxt  = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_err) begin
          w_state_nxt      = S_ERR_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end else if (w_accept) begin
          w_state_nxt     = S_ACC0;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = i_req_we;
          w_mem_be_nxt    = i_req_we ? w_st_be[3:0] : 4'd0;
          w_mem_addr_nxt  = w_word0;
          w_mem_wdata_nxt = i_req_we ? w_st_wide[31:0] : 32'd0;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_ACC0: begin
        if (r_cross) begin
          w_state_nxt     = S_ACC1;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = r_we;
          w_mem_be_nxt    = r_we ? r_be_hi : 4'd0;
          w_mem_addr_nxt  = r_word1;
          w_mem_wdata_nxt = r_we ? r_wdata_hi : 32'd0;
        end else if (r_we) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_CAP;
        end
      end
      S_ACC1: begin
        if (r_we) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_CAP;
        end
      end
      S_CAP: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = w_ld_data;
      end
      S_RESP, S_ERR_RESP: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  // Request context and first read word; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are always loaded before the FSM reads them.
    if (w_accept) begin
      r_we        <= i_req_we;
      r_off       <= w_off;
      r_size_code <= i_req_funct3[1:0];
      r_unsigned  <= i_req_funct3[2];
      r_cross     <= w_cross;
      r_word1     <= w_word0 + {{(ADDR_W-1){1'b0}}, 1'b1};
      r_wdata_hi  <= w_st_wide[63:32];
      r_be_hi     <= w_st_be[7:4];
    end
    if (r_state == S_ACC1) begin
      r_rdata0 <= i_mem_rdata;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_be     = r_mem_be;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural byte-lane memory.
// Expectations follow the LSU_SPLIT_CROSSING_EN setting of the build.
module tb_load_store_unit;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } acc_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q = 32'd0;
  acc_t        acc_q [$];

  int n_checks = 0;
  int n_errors = 0;

  int          lat;
  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_be     (mem_be),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // Byte-lane memory: writes on the edge ending an access, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      acc_q.push_back({mem_we, mem_be, mem_addr, mem_wdata});
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_q <= mem[mem_addr];
      end
    end
  end
  assign mem_rdata = rd_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc(input logic we, input logic [3:0] be,
                                      input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    return {17'd0, we, be, a, wd};
  endfunction

  // Logged access i; load entries drop the data field. Missing entries give all ones.
  function automatic logic [63:0] acc_at(input int i, input bit hdr_only);
    logic [63:0] v;
    if (i >= acc_q.size()) return '1;
    v = {17'd0, acc_q[i]};
    if (hdr_only) v[31:0] = 32'd0;
    return v;
  endfunction

  // One request from a negedge; returns latency in cycles (accept cycle = 0).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int l, output logic [31:0] r,
                        output logic e);
    int n;
    acc_q.delete();
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 64'd0, 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!resp_valid && l < 10);
    r = resp_rdata;
    e = resp_err;
    if (!resp_valid) l = 99;
    @(negedge clk);
    check("resp_pulse", {63'd0, resp_valid}, 64'd0);
    check("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp", {31'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
    check("rst_mem", {17'd0, mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Aligned word store and load.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, err);
    check("sw_lat", lat, 2);
    check("sw_err", {63'd0, err}, 64'd0);
    check("sw_acc", acc_at(0, 1'b0), enc(1'b1, 4'b1111, 10'd4, 32'hDEADBEEF));
    check("sw_nacc", acc_q.size(), 1);
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, err);
    check("lw_lat", lat, 3);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_acc", acc_at(0, 1'b1), enc(1'b0, 4'b0000, 10'd4, 32'd0));

    // Sign/zero extension on word 4 = 0x80FF7F01.
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, lat, rd, err);
    do_req(1'b0, 3'b000, 32'h11, 32'd0, lat, rd, err);
    check("lb_11", rd, 32'h0000007F);
    check("lb_lat", lat, 3);
    do_req(1'b0, 3'b000, 32'h12, 32'd0, lat, rd, err);
    check("lb_12", rd, 32'hFFFFFFFF);
    do_req(1'b0, 3'b101, 32'h12, 32'd0, lat, rd, err);
    check("lhu_12", rd, 32'h000080FF);
    do_req(1'b0, 3'b001, 32'h12, 32'd0, lat, rd, err);
    check("lh_12", rd, 32'hFFFF80FF);
    do_req(1'b0, 3'b001, 32'h11, 32'd0, lat, rd, err);
    check("lh_11_unaligned", {31'd0, err, rd}, {32'd0, 32'hFFFFFF7F});
    do_req(1'b0, 3'b100, 32'h13, 32'd0, lat, rd, err);
    check("lbu_13", rd, 32'h00000080);

    // Sub-word store lanes.
    do_req(1'b1, 3'b000, 32'h13, 32'h000000AA, lat, rd, err);
    check("sb_acc", acc_at(0, 1'b0), enc(1'b1, 4'b1000, 10'd4, 32'hAA000000));
    do_req(1'b1, 3'b001, 32'h11, 32'h00001234, lat, rd, err);
    check("sh_acc", acc_at(0, 1'b0), enc(1'b1, 4'b0110, 10'd4, 32'h00123400));
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, err);
    check("lw_after_sub", rd, 32'hAA123401);

    // Word-crossing accesses.
    do_req(1'b1, 3'b010, 32'h0C, 32'd0, lat, rd, err);
    do_req(1'b1, 3'b010, 32'h0E, 32'h11223344, lat, rd, err);
`ifdef LSU_SPLIT_CROSSING_EN
    check("sw_x_lat", lat, 3);
    check("sw_x_err", {63'd0, err}, 64'd0);
    check("sw_x_acc0", acc_at(0, 1'b0), enc(1'b1, 4'b1100, 10'd3, 32'h33440000));
    check("sw_x_acc1", acc_at(1, 1'b0), enc(1'b1, 4'b0011, 10'd4, 32'h00001122));
    do_req(1'b0, 3'b010, 32'h0E, 32'd0, lat, rd, err);
    check("lw_x_lat", lat, 4);
    check("lw_x_data", rd, 32'h11223344);
    check("lw_x_acc1", acc_at(1, 1'b1), enc(1'b0, 4'b0000, 10'd4, 32'd0));
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, err);
    check("w4_after_x", rd, 32'hAA121122);
`else
    check("sw_x_lat", lat, 1);
    check("sw_x_err", {63'd0, err}, 64'd1);
    check("sw_x_nacc", acc_q.size(), 0);
    do_req(1'b0, 3'b010, 32'h0E, 32'd0, lat, rd, err);
    check("lw_x_lat", lat, 1);
    check("lw_x_err", {31'd0, err, rd}, {32'd1, 32'd0});
    check("lw_x_nacc", acc_q.size(), 0);
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, err);
    check("w4_after_x", rd, 32'hAA123401);
`endif

    // Error responses and range boundary.
    do_req(1'b0, 3'b011, 32'h10, 32'd0, lat, rd, err);
    check("f3_011", {31'd0, err, rd}, {32'd1, 32'd0});
    check("f3_011_lat", lat, 1);
    do_req(1'b1, 3'b100, 32'h10, 32'h5, lat, rd, err);
    check("store_f3_100", {31'd0, err, rd}, {32'd1, 32'd0});
    check("store_f3_nacc", acc_q.size(), 0);
    do_req(1'b1, 3'b010, 32'h1000, 32'h5, lat, rd, err);
    check("sw_range", {31'd0, err}, 64'd1);
    check("sw_range_nacc", acc_q.size(), 0);
    do_req(1'b0, 3'b001, 32'hFFF, 32'd0, lat, rd, err);
    check("lh_fff", {31'd0, err, rd}, {32'd1, 32'd0});
    check("lh_fff_nacc", acc_q.size(), 0);
    do_req(1'b1, 3'b010, 32'hFFC, 32'hA5A5C3C3, lat, rd, err);
    do_req(1'b0, 3'b000, 32'hFFF, 32'd0, lat, rd, err);
    check("lb_fff", {31'd0, err, rd}, {32'd0, 32'hFFFFFFA5});
    check("lb_fff_acc", acc_at(0, 1'b1), enc(1'b0, 4'b0000, 10'h3FF, 32'd0));

    // Reset taking effect at the edge that ends the first word access.
    do_req(1'b1, 3'b010, 32'h14, 32'd0, lat, rd, err);
    do_req(1'b1, 3'b010, 32'h18, 32'd0, lat, rd, err);
    acc_q.delete();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
`ifdef LSU_SPLIT_CROSSING_EN
    req_addr   = 32'h16;
`else
    req_addr   = 32'h14;
`endif
    req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_acc0_en", {63'd0, mem_en}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_en", {63'd0, mem_en}, 64'd0);
    check("abort_ready_in_rst", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    check("abort_ready", {63'd0, req_ready}, 64'd1);
    check("abort_nacc", acc_q.size(), 1);
`ifdef LSU_SPLIT_CROSSING_EN
    check("abort_word0", mem[5], 32'hF00D0000);
`else
    check("abort_word0", mem[5], 32'hCAFEF00D);
`endif
    check("abort_word1", mem[6], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
